fifo_sync: RTL and testbench
============================

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameters SHALL be, one per line:
- DSIZE, 8, data width.
- ASIZE, 3, address width; depth = 2^ASIZE.
- FWFT, 1, 1 = first-word-fall-through; 0 = registered read.
- AFULL_TH, 6, WAFULL threshold (entries).
- AEMPTY_TH, 1, RAEMPTY threshold (entries).
REQ-002 Ports SHALL be, one per line:
- CLK in 1: single clock; all logic on rising edge.
- RST_N in 1: reset, synchronous, active-low.
- WDATA in DSIZE: write data.
- WINC in 1: write request.
- WFULL out 1: FIFO full.
- WAFULL out 1: level >= AFULL_TH.
- RINC in 1: read request.
- RDATA out DSIZE: read data.
- RVALID out 1: RDATA valid.
- REMPTY out 1: FIFO empty.
- RAEMPTY out 1: level <= AEMPTY_TH.
- LEVEL out ASIZE+1: current occupancy, 0..2^ASIZE.
REQ-003 The design SHALL use one clock, CLK, and a synchronous, active-low reset, RST_N.

Function
REQ-004 A write SHALL be accepted iff WINC && !WFULL; the entry is stored at wptr and wptr increments.
REQ-005 A read SHALL be accepted iff RINC && !REMPTY; rptr increments.
REQ-006 Pointers SHALL be ASIZE+1 bits and wrap modulo 2^(ASIZE+1); the MSB distinguishes full from empty.
REQ-007 LEVEL SHALL update one cycle after an accepted access: +1 write only, -1 read only, unchanged on both or neither.
REQ-008 WFULL, WAFULL, REMPTY and RAEMPTY SHALL be registered, derived from next-state LEVEL, and change in the same cycle as LEVEL.
REQ-009 Full with WINC && RINC: the read SHALL be accepted and the write rejected; data is not lost.
REQ-010 Empty with WINC && RINC: the write SHALL be accepted and the read rejected.
REQ-011 FWFT=1: RDATA SHALL present the head entry whenever !REMPTY, and RVALID = !REMPTY.
- Write into empty: REMPTY falls and RDATA is valid in the cycle after the write edge.
REQ-012 FWFT=0: an accepted read SHALL register mem[rptr] into RDATA, and RVALID pulses high for exactly the next cycle.
- RDATA holds its value otherwise.
REQ-013 Rejected requests SHALL leave pointers, LEVEL, memory and RDATA unchanged.

Reset
REQ-014 While RST_N=0 at a CLK edge: pointers = 0, LEVEL = 0, REMPTY = 1, RAEMPTY = 1, WFULL = 0, WAFULL = 0, RVALID = 0, RDATA = 0.
REQ-015 Reset SHALL take priority over WINC/RINC; reset mid-operation discards all contents.
- Memory array need not be cleared.

Configuration
REQ-016 Macro FIFO_SYNC_ERR_EN defined SHALL add:
- OVF out 1: sticky; set on WINC && WFULL.
- UDF out 1: sticky; set on RINC && REMPTY.
- ERR_CLR in 1: clears OVF and UDF; set wins over simultaneous clear; reset clears both.
REQ-017 Without FIFO_SYNC_ERR_EN: OVF, UDF and ERR_CLR SHALL be absent, and rejected requests are silently ignored.

Structure
REQ-018 Shared package fifo_pkg SHALL hold the level-width and depth constant functions and the default threshold constants.
REQ-019 Storage SHALL be sub-module fifo_sync_ram:
- Simple dual-port, one write and one read port, DSIZE x 2^ASIZE.
- Synchronous write; read asynchronous for FWFT=1, registered for FWFT=0.

Verification (DSIZE=8, ASIZE=3, AFULL_TH=6, AEMPTY_TH=1)
REQ-020 Write 0..7 with no reads -> LEVEL 8, WFULL=1, WAFULL=1 from 6; a 9th write is rejected and LEVEL stays 8.
REQ-021 Full, WINC=RINC=1 with WDATA=99 -> RDATA=0 consumed, 99 not stored, LEVEL 7.
REQ-022 Empty, WINC=RINC=1 with WDATA=5 -> LEVEL 1, REMPTY=0; FWFT=1: RDATA=5.
REQ-023 Write 12 items across a read stream -> pointers wrap and the output order is 0..11 exactly; FWFT=0: RVALID one cycle after each RINC.
REQ-024 RST_N=0 for one cycle with LEVEL 5 -> next cycle LEVEL 0, REMPTY=1, RAEMPTY=1, RVALID=0, RDATA=0.
REQ-025 FIFO_SYNC_ERR_EN: RINC while empty -> UDF=1 held; ERR_CLR together with WINC on full -> OVF stays 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the fifo_sync family.
package fifo_pkg;

  localparam int unsigned AFULL_TH_DEF  = 6;
  localparam int unsigned AEMPTY_TH_DEF = 1;

  // Occupancy and pointer width: one extra bit to tell full from empty.
  function automatic int unsigned level_w(input int unsigned asize);
    return asize + 32'd1;
  endfunction

  function automatic int unsigned depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port storage for fifo_sync: synchronous write, read port
// asynchronous when FWFT != 0, registered (loaded on re) otherwise.
module fifo_sync_ram #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 3,
  parameter int unsigned FWFT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_pkg::depth(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = (FWFT != 0) ? mem[raddr] : rdata_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy level and registered threshold flags.
// Optional sticky overflow/underflow flags under macro FIFO_SYNC_ERR_EN.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 3,
  parameter int unsigned FWFT      = 1,
  parameter int unsigned AFULL_TH  = AFULL_TH_DEF,
  parameter int unsigned AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [DSIZE-1:0] WDATA,
  input  logic             WINC,
  output logic             WFULL,
  output logic             WAFULL,
  input  logic             RINC,
  output logic [DSIZE-1:0] RDATA,
  output logic             RVALID,
  output logic             REMPTY,
  output logic             RAEMPTY,
  output logic [ASIZE:0]   LEVEL
`ifdef FIFO_SYNC_ERR_EN
  ,
  output logic             OVF,
  output logic             UDF,
  input  logic             ERR_CLR
`endif
);

  localparam int unsigned LW    = level_w(ASIZE);
  localparam int unsigned DEPTH = depth(ASIZE);

  logic [LW-1:0]    wptr;
  logic [LW-1:0]    rptr;
  logic [LW-1:0]    level_nxt;
  logic             wr_ok;
  logic             rd_ok;
  logic [DSIZE-1:0] ram_q;

  // Accept decisions use the registered flags, so full+both reads and empty+both writes.
  always_comb begin
    wr_ok     = WINC && !WFULL;
    rd_ok     = RINC && !REMPTY;
    level_nxt = LEVEL;
    if (wr_ok && !rd_ok)      level_nxt = LEVEL + LW'(1);
    else if (rd_ok && !wr_ok) level_nxt = LEVEL - LW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr    <= '0;
      rptr    <= '0;
      LEVEL   <= '0;
      WFULL   <= 1'b0;
      WAFULL  <= 1'b0;
      REMPTY  <= 1'b1;
      RAEMPTY <= 1'b1;
      RVALID  <= 1'b0;
    end else begin
      wptr    <= wptr + LW'(wr_ok);
      rptr    <= rptr + LW'(rd_ok);
      LEVEL   <= level_nxt;
      WFULL   <= level_nxt == LW'(DEPTH);
      WAFULL  <= level_nxt >= LW'(AFULL_TH);
      REMPTY  <= level_nxt == '0;
      RAEMPTY <= level_nxt <= LW'(AEMPTY_TH);
      RVALID  <= (FWFT != 0) ? (level_nxt != '0) : rd_ok;
    end
  end

  fifo_sync_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .FWFT  (FWFT)
  ) u_ram (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (wr_ok),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (WDATA),
    .re    (rd_ok),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (ram_q)
  );

  // Head entry is only meaningful while non-empty; force zero otherwise.
  assign RDATA = ((FWFT != 0) && REMPTY) ? '0 : ram_q;

`ifdef FIFO_SYNC_ERR_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      if (WINC && WFULL)  OVF <= 1'b1;
      else if (ERR_CLR)   OVF <= 1'b0;
      if (RINC && REMPTY) UDF <= 1'b1;
      else if (ERR_CLR)   UDF <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: one FWFT and one registered-read instance
// driven in lockstep, checked against a queue model, a vector table and corner sequences.
module tb_fifo_sync;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, winc, rinc;
  logic [7:0] wdata;
  logic       f0, af0, e0, ae0, v0, f1, af1, e1, ae1, v1;
  logic [7:0] d0, d1;
  logic [3:0] l0, l1;
`ifdef FIFO_SYNC_ERR_EN
  logic       err_clr = 1'b0;
  logic       ovf0, udf0, ovf1, udf1;
`endif

  fifo_sync #(.FWFT(1)) u0 (
    .CLK(clk), .RST_N(rst_n), .WDATA(wdata), .WINC(winc), .WFULL(f0), .WAFULL(af0),
    .RINC(rinc), .RDATA(d0), .RVALID(v0), .REMPTY(e0), .RAEMPTY(ae0), .LEVEL(l0)
`ifdef FIFO_SYNC_ERR_EN
    , .OVF(ovf0), .UDF(udf0), .ERR_CLR(err_clr)
`endif
  );

  fifo_sync #(.FWFT(0)) u1 (
    .CLK(clk), .RST_N(rst_n), .WDATA(wdata), .WINC(winc), .WFULL(f1), .WAFULL(af1),
    .RINC(rinc), .RDATA(d1), .RVALID(v1), .REMPTY(e1), .RAEMPTY(ae1), .LEVEL(l1)
`ifdef FIFO_SYNC_ERR_EN
    , .OVF(ovf1), .UDF(udf1), .ERR_CLR(err_clr)
`endif
  );

  int total = 0;
  int passed = 0;
  int q[$];
  int m_rd1 = 0;
  bit m_rv1 = 1'b0;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: drive, update the model at the edge, check #1 later.
  task automatic cyc(input bit r, input bit w, input bit rd, input int wd);
    bit wok, rok, clr;
    int n;
    rst_n = r; winc = w; rinc = rd; wdata = 8'(wd);
    clr = 1'b0;
`ifdef FIFO_SYNC_ERR_EN
    clr = err_clr;
`endif
    @(posedge clk);
    if (!r) begin
      q.delete(); m_rd1 = 0; m_rv1 = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      n   = q.size();
      wok = w && (n < 8);
      rok = rd && (n > 0);
      if (w && n == 8) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (rd && n == 0) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
      m_rv1 = rok;
      if (rok) m_rd1 = q.pop_front();
      if (wok) q.push_back(wd & 255);
    end
    #1;
    n = q.size();
    chk("level0", int'(l0), n);
    chk("level1", int'(l1), n);
    chk("wfull", int'(f0), int'(n == 8));
    chk("wafull", int'(af0), int'(n >= 6));
    chk("rempty", int'(e0), int'(n == 0));
    chk("raempty", int'(ae0), int'(n <= 1));
    chk("flags1", int'({f1, af1, e1, ae1}), int'({n == 8, n >= 6, n == 0, n <= 1}));
    chk("rdata_fwft", int'(d0), (n == 0) ? 0 : q[0]);
    chk("rvalid_fwft", int'(v0), int'(n != 0));
    chk("rdata_reg", int'(d1), m_rd1);
    chk("rvalid_reg", int'(v1), int'(m_rv1));
`ifdef FIFO_SYNC_ERR_EN
    chk("ovf", int'(ovf0), int'(m_ovf));
    chk("udf", int'(udf0), int'(m_udf));
    chk("err1", int'({ovf1, udf1}), int'({m_ovf, m_udf}));
`endif
  endtask

  typedef struct {
    bit r, w, rd;
    int wd;
    int level;
    bit full, afull, empty, aempty;
    int rdata;
  } vec_t;

  vec_t tbl[14];
  int   got0[$];
  int   got1[$];

  initial begin
    // Fill-to-full, 9th write rejected, full+both, reset, empty+both, drain.
    tbl[0] = '{r: 0, w: 0, rd: 0, wd: 0, level: 0, full: 0, afull: 0, empty: 1, aempty: 1, rdata: 0};
    for (int i = 0; i < 8; i++)
      tbl[1+i] = '{r: 1, w: 1, rd: 0, wd: i, level: i + 1, full: (i == 7), afull: (i >= 5),
                   empty: 0, aempty: (i == 0), rdata: 0};
    tbl[9]  = '{r: 1, w: 1, rd: 0, wd: 8,  level: 8, full: 1, afull: 1, empty: 0, aempty: 0, rdata: 0};
    tbl[10] = '{r: 1, w: 1, rd: 1, wd: 99, level: 7, full: 0, afull: 1, empty: 0, aempty: 0, rdata: 1};
    tbl[11] = '{r: 0, w: 0, rd: 0, wd: 0,  level: 0, full: 0, afull: 0, empty: 1, aempty: 1, rdata: 0};
    tbl[12] = '{r: 1, w: 1, rd: 1, wd: 5,  level: 1, full: 0, afull: 0, empty: 0, aempty: 1, rdata: 5};
    tbl[13] = '{r: 1, w: 0, rd: 1, wd: 0,  level: 0, full: 0, afull: 0, empty: 1, aempty: 1, rdata: 0};

    for (int k = 0; k < 14; k++) begin
      cyc(tbl[k].r, tbl[k].w, tbl[k].rd, tbl[k].wd);
      chk("tbl_level", int'(l0), tbl[k].level);
      chk("tbl_flags", int'({f0, af0, e0, ae0}),
          int'({tbl[k].full, tbl[k].afull, tbl[k].empty, tbl[k].aempty}));
      chk("tbl_rdata", int'(d0), tbl[k].rdata);
      if (k == 10) chk("full_both_consumed", int'(d1), 0);
    end

    // Pointer wrap: 12 items through a concurrent read stream, order preserved.
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i >= 2 && !e0) got0.push_back(int'(d0));
      cyc(1, i < 12, i >= 2, i);
      if (v1) got1.push_back(int'(d1));
    end
    chk("order_cnt_fwft", got0.size(), 12);
    chk("order_cnt_reg", got1.size(), 12);
    for (int j = 0; j < 12; j++) begin
      chk("order_fwft", (j < got0.size()) ? got0[j] : -1, j);
      chk("order_reg", (j < got1.size()) ? got1[j] : -1, j);
    end

    // Reset with five entries held discards everything.
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 40 + i);
    chk("pre_reset_level", int'(l0), 5);
    cyc(0, 1, 1, 7);
    chk("reset_level", int'(l0), 0);
    chk("reset_state", int'({e0, ae0, v0, v1, d0, d1}), int'({1'b1, 1'b1, 1'b0, 1'b0, 16'd0}));

`ifdef FIFO_SYNC_ERR_EN
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    chk("udf_held", int'(udf0), 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, i);
    err_clr = 1'b1;
    cyc(1, 1, 0, 9);
    chk("ovf_set_wins", int'(ovf0), 1);
    cyc(1, 0, 0, 0);
    err_clr = 1'b0;
    chk("err_cleared", int'({ovf0, udf0}), 0);
`endif

    // Randomized traffic with write-heavy and read-heavy phases and rare resets.
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      int bias;
      bias = ((i / 100) % 2 == 0) ? 75 : 25;
`ifdef FIFO_SYNC_ERR_EN
      err_clr = ($urandom_range(0, 15) == 0);
`endif
      cyc($urandom_range(0, 79) != 0, $urandom_range(0, 99) < bias,
          $urandom_range(0, 99) >= bias, int'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
